// File: rtl/umi_rx_fifo_if.sv
// -----------------------------------------------------------------------------
// umi_rx_fifo_if
//
// Purpose:
//   Single-direction valid/ready packet link that carries 256-bit UMI packets.
//   Word i of a packet occupies bits [32*i+31:32*i].
//
// Signals:
//   packet  256  packet payload, driven by the sender
//   valid   1    sender has a packet on 'packet'
//   ready   1    receiver accepts 'packet' this cycle
//
// Modports:
//   master  the sender: drives packet/valid and observes ready
//   slave   the receiver: observes packet/valid and drives ready
// -----------------------------------------------------------------------------
interface umi_rx_fifo_if;
    logic [255:0] packet;
    logic         valid;
    logic         ready;

    modport master (
        output packet,
        output valid,
        input  ready
    );

    modport slave (
        input  packet,
        input  valid,
        output ready
    );
endinterface

// File: rtl/umi_rx_fifo.sv
// -----------------------------------------------------------------------------
// umi_rx_fifo
//
// Purpose:
//   Elastic buffer placed right after the simulation UMI receive port. It
//   absorbs the 256-bit packet stream and re-presents it to the device under
//   test through the same valid/ready handshake, so DUT backpressure does not
//   stall the receive port. Occupancy and a high-water mark are exported for
//   bench diagnostics.
//
// Parameters:
//   DEPTH      number of 256-bit entries; power of two, at least 2
//   AW         derived pointer index width, $clog2(DEPTH)
//
// Ports:
//   clk        sole clock, rising edge
//   reset      asynchronous active-high reset
//   in_if      slave side of the upstream link (packet/valid in, ready out)
//   out_if     master side of the downstream link (packet/valid out, ready in)
//   count      current occupancy, 0..DEPTH
//   max_count  highest occupancy reached since reset, saturates at DEPTH
//
// Behaviour notes:
//   - First-word fall-through: out_if.packet is the head entry directly read
//     from the array; it is only meaningful while out_if.valid is high.
//   - No bypass: a packet written into an empty buffer is visible on the
//     output one cycle after it was accepted.
//   - in_if.ready depends on registered pointers only, so there is no
//     combinational path from out_if.ready to in_if.ready. When full, a pop
//     in the same cycle frees a slot that becomes writable on the next cycle.
// -----------------------------------------------------------------------------
module umi_rx_fifo #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    umi_rx_fifo_if.slave       in_if,
    umi_rx_fifo_if.master      out_if,
    output logic [AW:0]        count,
    output logic [AW:0]        max_count
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Packet storage; contents are deliberately not reset.
    logic [255:0] mem_q [DEPTH];

    // Pointers carry one extra MSB as a wrap bit so that full and empty can be
    // told apart when the index bits match.
    logic [AW:0] wr_ptr_q;
    logic [AW:0] wr_ptr_d;
    logic [AW:0] rd_ptr_q;
    logic [AW:0] rd_ptr_d;
    logic [AW:0] max_count_q;
    logic [AW:0] max_count_d;
    logic [AW:0] count_d;

    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign wr_idx = wr_ptr_q[AW-1:0];
    assign rd_idx = rd_ptr_q[AW-1:0];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // Handshake outputs come from registered pointers only.
    assign in_if.ready   = !full;
    assign out_if.valid  = !empty;
    assign out_if.packet = mem_q[rd_idx];

    assign push = in_if.valid && !full;
    assign pop  = !empty && out_if.ready;

    // Occupancy is the modulo difference of the pointers; with the wrap bit
    // this naturally spans 0..DEPTH.
    assign count     = wr_ptr_q - rd_ptr_q;
    assign max_count = max_count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        // High-water mark tracks the occupancy that will be visible after
        // this edge. count_d can never exceed DEPTH, so the mark saturates
        // there without extra logic.
        count_d     = wr_ptr_d - rd_ptr_d;
        max_count_d = max_count_q;
        if (count_d > max_count_q) begin
            max_count_d = count_d;
        end
    end

    // Control state: cleared asynchronously so buffered packets are discarded
    // and outputs fall to their idle values without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            max_count_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            max_count_q <= max_count_d;
        end
    end

    // Data array: written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_idx] <= in_if.packet;
        end
    end

endmodule

// File: tb/tb_umi_rx_fifo.sv
module tb_umi_rx_fifo;

    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic clk;
    logic reset;
    logic [AW:0] count;
    logic [AW:0] max_count;

    int checks;
    int errors;

    umi_rx_fifo_if in_if ();
    umi_rx_fifo_if out_if ();

    umi_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_if     (in_if),
        .out_if    (out_if),
        .count     (count),
        .max_count (max_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packet with word i = (seq << 8) | i; seq 0 gives word i = i.
    function automatic logic [255:0] mk_pkt(input int seq);
        logic [255:0] p;
        for (int i = 0; i < 8; i++) begin
            p[32*i +: 32] = 32'((seq << 8) | i);
        end
        return p;
    endfunction

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL reset_count got %0d want 0", count);
        end
        checks++;
        if (max_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_max got %0d want 0", max_count);
        end
        checks++;
        if (out_if.valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b want 0", out_if.valid);
        end
        checks++;
        if (in_if.ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_if.ready);
        end
        step();
        checks++;
        if (count !== 3'd0 || out_if.valid !== 1'b0) begin
            errors++;
            $display("FAIL idle got count=%0d valid=%b want 0/0", count, out_if.valid);
        end
    endtask

    task automatic test_single();
        in_if.packet = mk_pkt(0);
        in_if.valid  = 1'b1;
        out_if.ready = 1'b0;
        #1;
        checks++;
        if (out_if.valid !== 1'b0) begin
            errors++;
            $display("FAIL single_no_bypass got %b want 0", out_if.valid);
        end
        step();
        in_if.valid = 1'b0;
        checks++;
        if (out_if.valid !== 1'b1) begin
            errors++;
            $display("FAIL single_valid got %b want 1", out_if.valid);
        end
        checks++;
        if (out_if.packet !== mk_pkt(0)) begin
            errors++;
            $display("FAIL single_data got %h want %h", out_if.packet, mk_pkt(0));
        end
        checks++;
        if (count !== 3'd1) begin
            errors++;
            $display("FAIL single_count got %0d want 1", count);
        end
        out_if.ready = 1'b1;
        step();
        out_if.ready = 1'b0;
        checks++;
        if (count !== 3'd0 || out_if.valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pop got count=%0d valid=%b want 0/0", count, out_if.valid);
        end
    endtask

    task automatic test_fill();
        int seq;
        int exp_out;
        int cyc;
        logic acc;
        logic popped;
        logic [255:0] got;
        do_reset();
        out_if.ready = 1'b0;
        seq = 1;
        cyc = 0;
        in_if.valid = 1'b1;
        // Hold in_valid with 5 packets offered; only 4 fit.
        while (cyc < 8) begin
            in_if.packet = mk_pkt(seq);
            #1;
            acc = in_if.ready;
            step();
            if (acc) seq++;
            cyc++;
        end
        checks++;
        if (seq !== 5) begin
            errors++;
            $display("FAIL fill_accepted got %0d want 4", seq - 1);
        end
        checks++;
        if (in_if.ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_in_ready got %b want 0", in_if.ready);
        end
        checks++;
        if (count !== 3'd4) begin
            errors++;
            $display("FAIL fill_count got %0d want 4", count);
        end
        checks++;
        if (max_count !== 3'd4) begin
            errors++;
            $display("FAIL fill_max got %0d want 4", max_count);
        end
        // Drain with packet 5 still offered.
        out_if.ready = 1'b1;
        exp_out = 1;
        cyc = 0;
        while (exp_out <= 5 && cyc < 30) begin
            if (seq <= 5) begin
                in_if.packet = mk_pkt(seq);
                in_if.valid  = 1'b1;
            end else begin
                in_if.valid = 1'b0;
            end
            #1;
            acc = in_if.valid && in_if.ready;
            // First drain cycle is full: the push must be refused.
            if (cyc == 0) begin
                checks++;
                if (in_if.ready !== 1'b0) begin
                    errors++;
                    $display("FAIL full_pop_ready got %b want 0", in_if.ready);
                end
            end
            popped = out_if.valid;
            got    = out_if.packet;
            if (popped) begin
                checks++;
                if (got !== mk_pkt(exp_out)) begin
                    errors++;
                    $display("FAIL fill_order got %h want %h", got, mk_pkt(exp_out));
                end
            end
            step();
            if (popped) exp_out++;
            if (acc) seq++;
            cyc++;
        end
        in_if.valid = 1'b0;
        out_if.ready = 1'b0;
        checks++;
        if (exp_out !== 6) begin
            errors++;
            $display("FAIL fill_drain_timeout got %0d packets want 5", exp_out - 1);
        end
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL fill_empty got %0d want 0", count);
        end
    endtask

    task automatic test_back_to_back();
        int exp_out;
        logic [255:0] got;
        logic popped;
        exp_out = 0;
        out_if.ready = 1'b1;
        in_if.valid  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_if.packet = mk_pkt(c);
            #1;
            popped = out_if.valid;
            got    = out_if.packet;
            if (popped) begin
                checks++;
                if (got !== mk_pkt(exp_out)) begin
                    errors++;
                    $display("FAIL stream_order got %h want %h", got, mk_pkt(exp_out));
                end
            end
            step();
            if (popped) exp_out++;
            checks++;
            if (count !== 3'd1) begin
                errors++;
                $display("FAIL stream_count cycle %0d got %0d want 1", c, count);
            end
        end
        in_if.valid = 1'b0;
        #1;
        checks++;
        if (out_if.valid !== 1'b1 || out_if.packet !== mk_pkt(19)) begin
            errors++;
            $display("FAIL stream_last got valid=%b %h want 1 %h", out_if.valid, out_if.packet, mk_pkt(19));
        end
        step();
        out_if.ready = 1'b0;
        checks++;
        if (exp_out !== 19 || count !== 3'd0) begin
            errors++;
            $display("FAIL stream_end got popped=%0d count=%0d want 19/0", exp_out, count);
        end
    endtask

    task automatic test_reset_midop();
        out_if.ready = 1'b0;
        in_if.valid  = 1'b1;
        for (int s = 100; s < 103; s++) begin
            in_if.packet = mk_pkt(s);
            step();
        end
        in_if.valid = 1'b0;
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("FAIL midop_count got %0d want 3", count);
        end
        // Assert reset between edges; outputs must clear before the next edge.
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (count !== 3'd0 || out_if.valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got count=%0d valid=%b want 0/0", count, out_if.valid);
        end
        checks++;
        if (max_count !== 3'd0 || in_if.ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_aux got max=%0d ready=%b want 0/1", max_count, in_if.ready);
        end
        step();
        reset = 1'b0;
        in_if.packet = mk_pkt(200);
        in_if.valid  = 1'b1;
        step();
        in_if.valid = 1'b0;
        checks++;
        if (out_if.valid !== 1'b1 || out_if.packet !== mk_pkt(200)) begin
            errors++;
            $display("FAIL post_reset_data got valid=%b %h want 1 %h", out_if.valid, out_if.packet, mk_pkt(200));
        end
        out_if.ready = 1'b1;
        step();
        out_if.ready = 1'b0;
        checks++;
        if (out_if.valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL post_reset_empty got valid=%b count=%0d want 0/0", out_if.valid, count);
        end
    endtask

    task automatic test_random();
        logic [255:0] q[$];
        int next_seq;
        int peak;
        logic push;
        logic pop;
        do_reset();
        next_seq = 1000;
        peak = 0;
        for (int c = 0; c < 10000; c++) begin
            in_if.valid  = 1'($urandom_range(0, 1));
            in_if.packet = mk_pkt(next_seq);
            out_if.ready = 1'($urandom_range(0, 1));
            #1;
            push = in_if.valid && (q.size() < DEPTH);
            pop  = out_if.ready && (q.size() > 0);
            checks++;
            if (in_if.ready !== (q.size() < DEPTH) || out_if.valid !== (q.size() > 0)) begin
                errors++;
                $display("FAIL rand_flags cycle %0d got ready=%b valid=%b size=%0d", c, in_if.ready, out_if.valid, q.size());
            end
            if (q.size() > 0) begin
                checks++;
                if (out_if.packet !== q[0]) begin
                    errors++;
                    $display("FAIL rand_data cycle %0d got %h want %h", c, out_if.packet, q[0]);
                end
            end
            step();
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(mk_pkt(next_seq));
                next_seq++;
            end
            if (q.size() > peak) peak = q.size();
            checks++;
            if (count !== 3'(q.size())) begin
                errors++;
                $display("FAIL rand_count cycle %0d got %0d want %0d", c, count, q.size());
            end
        end
        in_if.valid  = 1'b0;
        out_if.ready = 1'b0;
        checks++;
        if (max_count !== 3'(peak)) begin
            errors++;
            $display("FAIL rand_max got %0d want %0d", max_count, peak);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        in_if.valid  = 1'b0;
        in_if.packet = '0;
        out_if.ready = 1'b0;
        #12;
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
